// File: rtl/fir_pkg.sv
// Shared defaults, edge-FSM state type and saturation counter width for the
// FIR output stage.
package fir_pkg;

   localparam int P_W_DEF       = 48;
   localparam int OUT_W_DEF     = 8;
   localparam int FRAC_BITS_DEF = 16;
   localparam int SAT_CNT_W     = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HEAD = 2'd1,
      BODY = 2'd2
   } edge_state_t;

endpackage

// File: rtl/sync_delay.sv
// Fixed-depth shift register used to align video control with the DSP chain.
// Asynchronous active-low reset clears every stage.
module sync_delay
   import fir_pkg::*;
#(
   parameter int WIDTH = 3,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] sr [DEPTH];

   // shift one stage per clock; stage 0 takes the live input
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
      end else begin
         sr[0] <= d;
         for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
      end
   end

   assign q = sr[DEPTH-1];

endmodule

// File: rtl/fir_out_stage.sv
// Output end of the symmetric FIR chain: rounds the 48-bit accumulator,
// clamps it to an unsigned pixel, realigns valid/sync and blanks the first
// HALF pixels of every line. Optional per-frame saturation counter is built
// only when FIR_SAT_CNT_EN is defined.
module fir_out_stage
   import fir_pkg::*;
#(
   parameter int P_W       = P_W_DEF,
   parameter int FRAC_BITS = FRAC_BITS_DEF,
   parameter int OUT_W     = OUT_W_DEF,
   parameter int DSP_LAT   = 4,
   parameter int TAPS      = 11,
   parameter int BLANK_VAL = 0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 dv_i,
   input  logic                 hs_i,
   input  logic                 vs_i,
   input  logic [P_W-1:0]       p_i,
   output logic                 dv_o,
   output logic                 hs_o,
   output logic                 vs_o,
   output logic [OUT_W-1:0]     pix_o,
   output logic                 sat_o,
   output logic [SAT_CNT_W-1:0] sat_cnt_o
);

   localparam int HALF  = (TAPS - 1) / 2;
   localparam int CNT_W = (HALF < 1) ? 1 : $clog2(HALF + 1);

   function automatic logic signed [P_W:0] round_half_up(input logic signed [P_W-1:0] v);
      logic signed [P_W:0] half;
      half = '0;
      half[FRAC_BITS-1] = 1'b1;
      return $signed({v[P_W-1], v}) + half;
   endfunction

   // returns {sat, pix}
   function automatic logic [OUT_W:0] clamp_pix(input logic signed [P_W:0] r);
      logic signed [P_W:0] q;
      q = r >>> FRAC_BITS;
      if (q[P_W])               return {1'b1, {OUT_W{1'b0}}};
      else if (|q[P_W:OUT_W])   return {1'b1, {OUT_W{1'b1}}};
      else                      return {1'b0, q[OUT_W-1:0]};
   endfunction

   // fill_a marks delay-line contents written after reset, so the flushed
   // zeros are not mistaken for a real dv low.
   logic fill_a, dv_a, hs_a, vs_a;

   sync_delay #(.WIDTH(4), .DEPTH(DSP_LAT)) u_align (
      .clk   (clk),
      .rst_n (rst_n),
      .d     ({1'b1, dv_i, hs_i, vs_i}),
      .q     ({fill_a, dv_a, hs_a, vs_a})
   );

   edge_state_t      state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
   logic             dv_a_q, vs_a_q, armed, blank_a, dv_rise;

   assign cnt_inc = cnt + 1'b1;
   assign dv_rise = dv_a & ~dv_a_q & armed;

   // edge FSM next state and blank decision for the aligned pixel
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      blank_a   = dv_a & ~armed;
      case (state)
         IDLE: begin
            if (dv_rise) begin
               blank_a = (HALF > 0);
               if (HALF <= 1) begin
                  state_nxt = BODY;
               end else begin
                  state_nxt = HEAD;
                  cnt_nxt   = CNT_W'(1);
               end
            end
         end
         HEAD: begin
            if (!dv_a) begin
               state_nxt = IDLE;
            end else begin
               blank_a = 1'b1;
               cnt_nxt = cnt_inc;
               if (cnt_inc == CNT_W'(HALF)) state_nxt = BODY;
            end
         end
         BODY: begin
            if (!dv_a) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      if (vs_a & ~vs_a_q) begin
         state_nxt = IDLE;
         cnt_nxt   = '0;
      end
   end

   // edge FSM state and head counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // edge history; armed once a genuine dv low has been seen after reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dv_a_q <= 1'b0;
         vs_a_q <= 1'b0;
         armed  <= 1'b0;
      end else begin
         dv_a_q <= dv_a;
         vs_a_q <= vs_a;
         armed  <= armed | (fill_a & ~dv_a);
      end
   end

   logic signed [P_W:0] r1_p1;
   logic                dv_p1, hs_p1, vs_p1, blank_p1;
   logic [OUT_W:0]      clamp_p1;

   // stage 1: rounding add, aligned control registered alongside
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r1_p1    <= '0;
         dv_p1    <= 1'b0;
         hs_p1    <= 1'b0;
         vs_p1    <= 1'b0;
         blank_p1 <= 1'b0;
      end else begin
         r1_p1    <= round_half_up(p_i);
         dv_p1    <= dv_a;
         hs_p1    <= hs_a;
         vs_p1    <= vs_a;
         blank_p1 <= blank_a;
      end
   end

   assign clamp_p1 = clamp_pix(r1_p1);

   // stage 2: shift/clamp and output mux
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dv_o  <= 1'b0;
         hs_o  <= 1'b0;
         vs_o  <= 1'b0;
         pix_o <= '0;
         sat_o <= 1'b0;
      end else begin
         dv_o <= dv_p1;
         hs_o <= hs_p1;
         vs_o <= vs_p1;
         if (!dv_p1) begin
            pix_o <= '0;
            sat_o <= 1'b0;
         end else if (blank_p1) begin
            pix_o <= OUT_W'(BLANK_VAL);
            sat_o <= 1'b0;
         end else begin
            pix_o <= clamp_p1[OUT_W-1:0];
            sat_o <= clamp_p1[OUT_W];
         end
      end
   end

`ifdef FIR_SAT_CNT_EN
   logic [SAT_CNT_W-1:0] sat_acc;
   logic                 vs_o_q;

   // per-frame saturation count, latched and restarted on vs_o rising
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sat_acc   <= '0;
         sat_cnt_o <= '0;
         vs_o_q    <= 1'b0;
      end else begin
         vs_o_q <= vs_o;
         if (vs_o & ~vs_o_q) begin
            sat_cnt_o <= sat_acc;
            sat_acc   <= {{(SAT_CNT_W-1){1'b0}}, sat_o};
         end else if (sat_o && (sat_acc != {SAT_CNT_W{1'b1}})) begin
            sat_acc <= sat_acc + 1'b1;
         end
      end
   end
`else
   assign sat_cnt_o = '0;
`endif

endmodule

// File: doc/fir_out_stage.md
Name: fir_out_stage

Overview:
- Output end of the symmetric FIR chain built from cascaded 25x18 pre-subtract DSP slices.
- Consumes the 48-bit accumulator from the last slice and rounds it by FRAC_BITS.
- Clamps the result to an unsigned OUT_W-bit pixel.
- Realigns video valid/sync with the DSP pipeline and blanks the filter's leading edge pixels on every line.

Parameters:
- P_W, 48, width of accumulator input.
- FRAC_BITS, 16, fractional bits of coefficient scaling; must be 1..P_W-OUT_W-1.
- OUT_W, 8, output pixel width.
- DSP_LAT, 4, cycles from dv_i/hs_i/vs_i to the matching p_i sample; must be >= 1.
- TAPS, 11, odd filter length; HALF = (TAPS-1)/2 leading pixels are blanked per line.
- BLANK_VAL, 0, pixel value driven for blanked pixels.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- dv_i  in  1  pixel valid at filter input.
- hs_i  in  1  hsync at filter input.
- vs_i  in  1  vsync at filter input.
- p_i  in  P_W  signed accumulator from last DSP slice, aligned DSP_LAT cycles after dv_i.
- dv_o  out  1  pixel valid out.
- hs_o  out  1  hsync out.
- vs_o  out  1  vsync out.
- pix_o  out  OUT_W  unsigned filtered pixel.
- sat_o  out  1  one-cycle flag: pix_o was clamped.
- sat_cnt_o  out  16  per-frame saturation count; tied to 0 without FIR_SAT_CNT_EN.

Behaviour:
- Reset: rst_n low asynchronously clears all delay lines, pipeline registers, FSM (IDLE), counters. All outputs read 0 while reset is asserted.
- Sync path: dv/hs/vs go through a DSP_LAT-deep shift register (aligned *_a, coincident with p_i), then 2 more stages. Total dv_i to dv_o latency is DSP_LAT+2; p_i to pix_o latency is 2.
- Stage 1: r1 = p_i + 2^(FRAC_BITS-1), computed in P_W+1 bits signed (round half up), registered.
- Stage 2: q = r1 >>> FRAC_BITS (arithmetic).
  - If q < 0: pix = 0, sat = 1.
  - Else if q > 2^OUT_W-1: pix = 2^OUT_W-1, sat = 1.
  - Else: pix = q[OUT_W-1:0], sat = 0.
- Edge FSM, evaluated on the aligned dv_a, with a counter of width clog2(HALF+1):
  - IDLE: dv_a 0→1 goes to HEAD, cnt = 1. If HALF = 0, goes straight to BODY.
  - HEAD: each dv_a=1 cycle, cnt++. Go to BODY when cnt == HALF and dv_a = 1. dv_a = 0 returns to IDLE (short line, fully blanked).
  - BODY: dv_a = 0 returns to IDLE.
  - Gaps of dv_a within a line end the line.
  - Rising edge of vs_a forces IDLE regardless of state; vs_a has priority over dv_a in the same cycle.
  - Blank decision for an aligned pixel: in IDLE with dv_a rising (first pixel) or in HEAD.
- Output mux, stage 2 registered:
  - pix_o = BLANK_VAL, sat_o = 0 for blanked pixels.
  - pix_o = 0, sat_o = 0 when dv is low.
  - Otherwise the clamped value and sat.
  - sat_o is never 1 while dv_o = 0.
- Reset released mid-line: FSM is in IDLE but dv_a was never seen low. Require a dv_a low before accepting a rising edge; pixels of the partial line are blanked and dv_o still passes through.
- No backpressure; the block accepts one sample per clock unconditionally.

Optional Feature:
- Macro FIR_SAT_CNT_EN.
- Defined:
  - A 16-bit counter increments on each sat_o = 1 and saturates at 0xFFFF.
  - On a vs_o rising edge, sat_cnt_o latches the counter and the counter clears. A sat event in that same cycle counts into the new frame.
  - Reset clears both counter and sat_cnt_o.
- Undefined: sat_cnt_o = 0 constant and no counter logic is built.

Decomposition:
- Package fir_pkg holds:
  - default P_W/OUT_W/FRAC_BITS;
  - edge FSM state enum (IDLE, HEAD, BODY);
  - the 16-bit sat counter width constant.
- Sub-module sync_delay (parameters WIDTH, DEPTH; async active-low reset shift register) is instantiated for the {dv,hs,vs} alignment.

Test Plan:
All scenarios use defaults (FRAC_BITS=16, DSP_LAT=4, TAPS=11).
- Rounding: p_i = 0x000000648000 → pix_o = 101; p_i = 0x000000647FFF → pix_o = 100; both appear 2 cycles after p_i.
- Clamping: p_i = -0x10000 → pix_o = 0, sat_o = 1; p_i = 0x000001000000 → pix_o = 255, sat_o = 1; p_i = 0x0000FF0000 → 255, sat_o = 0.
- Line of 20 dv_i pulses with p_i = 50<<16 → dv_o high 20 cycles starting DSP_LAT+2 after dv_i; first 5 pix_o = 0, next 15 = 50.
- Short line of 3 dv_i → 3 blanked pixels, FSM back in IDLE; the following 20-pixel line blanks exactly 5 again.
- rst_n pulled low at pixel 8 of a line → all outputs 0 immediately. Release with dv_i still high → the remaining pixels of that line are blanked; the next line is normal.
- FIR_SAT_CNT_EN: frame with 7 saturating pixels (2 in the HEAD region, not counted) → sat_cnt_o = 5 after the next vs_o rising edge; 70000 events → 0xFFFF.
